// File: rtl/line_drawer.sv
// line_drawer
// Bresenham line rasteriser. A line request (x1,y1)->(x2,y2) is accepted while
// idle. The block then emits every pixel of the line, endpoints included, on a
// valid/ready style pixel port. Pixels that fall outside the active area are
// skipped internally. They are never offered to the framebuffer.
//
// Ports
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   start        line request, sampled only while ready=1
//   ready        high while idle and able to take a new line
//   x1, y1       line start point (latched on an accepted start)
//   x2, y2       line end point (latched on an accepted start)
//   pixel_x/y    coordinate currently offered to the framebuffer
//   pixel_write  pixel write request
//   pixel_ready  framebuffer accepts; transfer when pixel_write & pixel_ready
module line_drawer #(
   parameter int HOR_ACTIVE_PIXELS = 640,
   parameter int VER_ACTIVE_PIXELS = 480,
   localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
   localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   output logic               ready,
   input  logic [X_WIDTH-1:0] x1,
   input  logic [Y_WIDTH-1:0] y1,
   input  logic [X_WIDTH-1:0] x2,
   input  logic [Y_WIDTH-1:0] y2,
   output logic [X_WIDTH-1:0] pixel_x,
   output logic [Y_WIDTH-1:0] pixel_y,
   output logic               pixel_write,
   input  logic               pixel_ready
);

   // Two guard bits above the widest coordinate keep 2*err from overflowing
   // for any pair of endpoints.
   localparam int W = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;

   localparam logic [X_WIDTH:0] H_LIMIT = (X_WIDTH + 1)'(HOR_ACTIVE_PIXELS);
   localparam logic [Y_WIDTH:0] V_LIMIT = (Y_WIDTH + 1)'(VER_ACTIVE_PIXELS);

   typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

   state_t               state;
   logic [X_WIDTH-1:0]   x1_q, x2_q, cur_x;
   logic [Y_WIDTH-1:0]   y1_q, y2_q, cur_y;
   logic signed [W-1:0]  dx, dy, err;
   logic                 sx_neg, sy_neg;
   logic                 primed;

   logic signed [W-1:0]  setup_dx, setup_dy, e2, next_err;
   logic                 step_x, step_y;
   logic [X_WIDTH-1:0]   next_x;
   logic [Y_WIDTH-1:0]   next_y;
   logic                 next_clipped, cur_clipped, at_end, advance;

   assign ready = (state == IDLE);

   // Setup deltas come from the latched endpoints, so input changes after
   // acceptance cannot disturb the line. The stepping logic computes the
   // following Bresenham point from cur and err. When both tests pass, x and
   // y move together (a diagonal step).
   always_comb begin
      setup_dx = (x2_q > x1_q) ? W'(x2_q) - W'(x1_q) : W'(x1_q) - W'(x2_q);
      setup_dy = (y2_q > y1_q) ? W'(y1_q) - W'(y2_q) : W'(y2_q) - W'(y1_q);
      e2       = err <<< 1;
      step_x   = (e2 >= dy);
      step_y   = (e2 <= dx);
      next_err = err;
      next_x   = cur_x;
      next_y   = cur_y;
      if (step_x) begin
         next_err = next_err + dy;
         next_x   = sx_neg ? cur_x - X_WIDTH'(1) : cur_x + X_WIDTH'(1);
      end
      if (step_y) begin
         next_err = next_err + dx;
         next_y   = sy_neg ? cur_y - Y_WIDTH'(1) : cur_y + Y_WIDTH'(1);
      end
      cur_clipped  = ({1'b0, cur_x} >= H_LIMIT) || ({1'b0, cur_y} >= V_LIMIT);
      next_clipped = ({1'b0, next_x} >= H_LIMIT) || ({1'b0, next_y} >= V_LIMIT);
      at_end       = (cur_x == x2_q) && (cur_y == y2_q);
      // A clipped pixel is shown with pixel_write=0, so it moves on at once.
      advance      = pixel_ready || !pixel_write;
   end

   // Main controller. DRAW uses a priming cycle to load the first pixel onto
   // the registered output port. After that, cur always matches pixel_x/y.
   // The block steps only when that pixel transfers or is clipped. While a
   // write stalls, every register holds.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         x1_q        <= '0;
         y1_q        <= '0;
         x2_q        <= '0;
         y2_q        <= '0;
         cur_x       <= '0;
         cur_y       <= '0;
         dx          <= '0;
         dy          <= '0;
         err         <= '0;
         sx_neg      <= 1'b0;
         sy_neg      <= 1'b0;
         primed      <= 1'b0;
         pixel_x     <= '0;
         pixel_y     <= '0;
         pixel_write <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  x1_q  <= x1;
                  y1_q  <= y1;
                  x2_q  <= x2;
                  y2_q  <= y2;
                  state <= SETUP;
               end
            end
            SETUP: begin
               dx     <= setup_dx;
               dy     <= setup_dy;
               err    <= setup_dx + setup_dy;
               sx_neg <= !(x1_q < x2_q);
               sy_neg <= !(y1_q < y2_q);
               cur_x  <= x1_q;
               cur_y  <= y1_q;
               primed <= 1'b0;
               state  <= DRAW;
            end
            DRAW: begin
               if (!primed) begin
                  pixel_x     <= cur_x;
                  pixel_y     <= cur_y;
                  pixel_write <= !cur_clipped;
                  primed      <= 1'b1;
               end else if (advance) begin
                  if (at_end) begin
                     pixel_write <= 1'b0;
                     primed      <= 1'b0;
                     state       <= IDLE;
                  end else begin
                     cur_x       <= next_x;
                     cur_y       <= next_y;
                     err         <= next_err;
                     pixel_x     <= next_x;
                     pixel_y     <= next_y;
                     pixel_write <= !next_clipped;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/line_drawer.md
LINE_DRAWER -- requirements
Module: line_drawer

Interface
REQ-001 HOR_ACTIVE_PIXELS, default 640, horizontal active width in pixels; X_WIDTH = clog2(HOR_ACTIVE_PIXELS).
REQ-002 VER_ACTIVE_PIXELS, default 480, vertical active height in pixels; Y_WIDTH = clog2(VER_ACTIVE_PIXELS).
REQ-003 clk  input  1  single clock; all logic SHALL be on the rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  request to draw a line; sampled only while ready=1.
REQ-006 ready  output  1  high when idle and able to accept start.
REQ-007 x1, y1  input  X_WIDTH, Y_WIDTH  start point; latched on accepted start.
REQ-008 x2, y2  input  X_WIDTH, Y_WIDTH  end point; latched on accepted start.
REQ-009 pixel_x, pixel_y  output  X_WIDTH, Y_WIDTH  coordinate of the pixel being written.
REQ-010 pixel_write  output  1  pixel write request to the framebuffer.
REQ-011 pixel_ready  input  1  framebuffer can accept; write transfers on an edge where pixel_write=1 and pixel_ready=1.

Function
REQ-012 The FSM SHALL have states IDLE, SETUP, DRAW; ready SHALL equal (state==IDLE).
REQ-013 IDLE: start=1 SHALL latch x1,y1,x2,y2 and go to SETUP; start=0 SHALL hold IDLE.
REQ-014 SETUP (one cycle) SHALL compute dx=|x2-x1|, dy=-|y2-y1|, sx=(x1<x2)?+1:-1, sy=(y1<y2)?+1:-1, err=dx+dy, cur=(x1,y1), then go to DRAW.
REQ-015 dx, dy, err and e2 SHALL be signed, max(X_WIDTH,Y_WIDTH)+2 bits wide, with no overflow for any input.
REQ-016 Latency: start accepted at edge N -> ready=0 after edge N; pixel_write=1 with the first pixel after edge N+2.
REQ-017 DRAW SHALL present cur on pixel_x/pixel_y, with pixel_write=1 unless cur is clipped (REQ-020).
REQ-018 On a transfer, or on a clipped pixel, the block SHALL advance using e2=2*err: if e2>=dy then err+=dy and x+=sx; if e2<=dx then err+=dx and y+=sy; both updates SHALL apply in the same cycle when both conditions hold.
REQ-019 While pixel_write=1 and pixel_ready=0, pixel_x, pixel_y, pixel_write and all internal state SHALL hold; no pixel is skipped or duplicated.
REQ-020 A pixel with x>=HOR_ACTIVE_PIXELS or y>=VER_ACTIVE_PIXELS SHALL be clipped: pixel_write=0 for it, and stepping continues on the next edge without waiting for pixel_ready.
REQ-021 When the transferred or clipped pixel equals (x2,y2), the FSM SHALL return to IDLE with pixel_write=0 after that edge.
REQ-022 Pixels SHALL be emitted in order from (x1,y1) to (x2,y2), endpoints inclusive, at one pixel per cycle with pixel_ready=1.
REQ-023 A degenerate line (x1==x2 and y1==y2) SHALL emit exactly one pixel.
REQ-024 start while ready=0 SHALL be ignored, and the line in progress SHALL be unaffected.
REQ-025 Changes on x1..y2 after acceptance SHALL NOT affect the line in progress.

Reset
REQ-026 reset_n=0 at an edge SHALL set state=IDLE, ready=1, pixel_write=0, pixel_x=0, pixel_y=0 and clear internal registers.
REQ-027 Reset SHALL take priority over all other inputs, including mid-line and during a stall; a start on the first edge with reset_n=1 SHALL be accepted.

Verification
REQ-028 Horizontal line (0,5)->(3,5), pixel_ready=1 -> writes (0,5),(1,5),(2,5),(3,5) on consecutive cycles, first at N+2; ready=1 after the last transfer.
REQ-029 Reverse diagonal (3,3)->(0,0) -> (3,3),(2,2),(1,1),(0,0). Steep line (0,0)->(1,3) -> (0,0),(0,1),(1,2),(1,3).
REQ-030 Line (0,0)->(3,0), with pixel_ready held low for 3 cycles while (1,0) is presented -> (1,0) held stable for 4 cycles and transferred once; total sequence is (0,0),(1,0),(2,0),(3,0).
REQ-031 Degenerate line (7,7)->(7,7) -> one write of (7,7); a start pulse applied during that line, with different coordinates, is ignored.
REQ-032 Clip: (638,10)->(641,10) with HOR_ACTIVE_PIXELS=640 -> writes only (638,10),(639,10); ready=1 two cycles after the last write.
REQ-033 reset_n=0 while writing the second pixel of (0,0)->(9,0) -> next edge: ready=1, pixel_write=0; a new start for (2,2)->(2,4) then yields (2,2),(2,3),(2,4).
